gpio_sample_requester: RTL and testbench
========================================

# gpio_sample_requester

Sample-request master for the external GPIO audio link. It drives the request line read by the core through the PIO (GPIO0[17]) at a programmable sample rate. It completes a four-phase req/ack handshake with the core's firmware and captures the sample word the core presents on GPIO outputs into a small FIFO for the downstream DAC/serializer. It doubles as the bench-side and FPGA-side counterpart of the core's sample-service loop, so the loop can be exercised without a free-running square-wave request.

## Interface
- DATA_W, 16, width of captured sample word
- FIFO_DEPTH, 8, capture FIFO entries (power of two, ≥2)
- TIMEOUT, 1024, cycles allowed in REQ before abandoning a request
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset (0 = reset asserted)
- enable  in  1  1 = generate periodic requests
- period  in  16  clocks per sample period; values <4 treated as 4
- clear  in  1  synchronous pulse: clears sticky flags and counters
- req  out  1  request to core (drives GPIO0[17])
- ack  in  1  acknowledge from core GPIO output (asynchronous to clk)
- sample  in  DATA_W  sample word from core GPIO outputs, stable while ack=1
- out_valid  out  1  FIFO not empty
- out_data  out  DATA_W  FIFO head
- out_ready  in  1  downstream pops head when out_valid & out_ready
- overrun  out  1  sticky: sample dropped, FIFO full
- timeout  out  1  sticky: request abandoned after TIMEOUT
- missed  out  16  saturating count of period ticks that found the FSM busy
- sample_count  out  32  wrapping count of samples pushed into the FIFO

## Operation
- ack is synchronised by two flops to ack_s; sample is not synchronised (the protocol guarantees stability while ack_s=1).
- Period counter: while enable=1, it counts down from max(period,4)-1 and emits tick on reaching 0, then reloads. While enable=0, it holds at the reload value. A change of period takes effect at the next reload.
- FSM states:
  - IDLE: req=0. On tick, go to REQ.
  - REQ: req=1, timeout counter runs.
    - If ack_s=1: capture sample, push to FIFO, go to WAIT_LOW.
    - Else if the timeout counter reaches TIMEOUT-1: set timeout, go to WAIT_LOW without push.
  - WAIT_LOW: req=0. When ack_s=0, go to IDLE.
- A tick in REQ or WAIT_LOW increments missed, saturating at 16'hFFFF, and is otherwise discarded.
- Deasserting enable does not abort an in-flight handshake; the FSM finishes to IDLE.
- FIFO: push on capture, pop on out_valid & out_ready.
  - Push when full and no pop: the sample is dropped, overrun is set, and sample_count is unchanged.
  - Push and pop in the same cycle while full: both succeed.
  - Pop when empty is ignored.
- clear zeroes overrun, timeout, missed and sample_count. It does not touch the FIFO or the FSM. If clear coincides with an event that would set a flag or increment a counter, clear wins.
- Reset asserted (any time, mid-handshake included) forces the following, immediately and asynchronously:
  - IDLE, req=0, FIFO empty, out_valid=0, out_data=0
  - all flags and counters 0, sync flops 0, period counter at reload

## Timing
- Reset values: req=0, out_valid=0, out_data=0, overrun=0, timeout=0, missed=0, sample_count=0.
- With enable rising at edge E and period=P (P≥4), the first tick is at edge E+P and subsequent ticks are every P edges.
- req rises on the edge after tick.
- ack at pin high before edge k ⇒ ack_s=1 after edge k+1 ⇒ capture and req=0 at edge k+2.
- Captured sample visible at out_data/out_valid on the edge after the push when the FIFO was empty.
- Minimum handshake is 6 clocks (req up, 2 sync, capture, ack down sync 2). Hence the period≥4 floor, with missed reporting slow responders.
- The timeout counter clears on entry to REQ. TIMEOUT cycles in REQ without ack_s cause the exit.

## Test plan
- Reset release, enable=1, period=10, core model acks 3 clocks after req, sample=16'h1234 → req period 10 clocks, out_data=16'h1234, out_valid=1, sample_count=1, missed=0.
- Core model never acks, TIMEOUT=1024 → req high exactly 1024 cycles then low, timeout=1, no push. The next tick starts a new request.
- out_ready=0, 9 completed handshakes with FIFO_DEPTH=8 → 8 entries in order, overrun=1, sample_count=8. Then out_ready=1 drains the 8 in push order.
- period=4, ack delay 10 clocks → missed increments on every overlapping tick; check against the cycle count. clear pulse → missed=0, sample_count=0.
- Full FIFO with out_ready=1 at the same cycle as capture → no overrun, count stays 8, head advances.
- Reset asserted while req=1 and ack=1 → req=0, out_valid=0 asynchronously. After release, no capture until a fresh tick and the ack low→high sequence.

Source files
------------

// File: rtl/gpio_sample_requester_if.sv
// Handshake and capture-stream signals between the sample requester and
// the core / downstream DAC.
interface gpio_sample_requester_if #(
    parameter int DATA_W = 16
);
    logic              req;
    logic              ack;
    logic [DATA_W-1:0] sample;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_ready;

    modport master (
        output req, out_valid, out_data,
        input  ack, sample, out_ready
    );

    modport slave (
        input  req, out_valid, out_data,
        output ack, sample, out_ready
    );
endinterface

// File: rtl/gpio_sample_requester.sv
// Periodic sample-request master: drives req to the core, completes the
// four-phase req/ack handshake and queues captured words for the DAC.
//
//   state    | meaning
//   IDLE     | req low, waiting for a period tick
//   REQ      | req high, waiting for synchronised ack or timeout
//   WAIT_LOW | req low, waiting for the core to drop ack
module gpio_sample_requester #(
    parameter int DATA_W     = 16,
    parameter int FIFO_DEPTH = 8,
    parameter int TIMEOUT    = 1024
) (
    input  logic                    clk,
    input  logic                    rst_n,
    gpio_sample_requester_if.master bus,
    input  logic                    enable_i,
    input  logic [15:0]             period_i,
    input  logic                    clear_i,
    output logic                    overrun_o,
    output logic                    timeout_o,
    output logic [15:0]             missed_o,
    output logic [31:0]             sample_count_o
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);
    localparam logic [AW:0]   DEPTH_L = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, REQ, WAIT_LOW} state_t;

    state_t            state_q;
    logic              req_q;
    logic [TW-1:0]     to_cnt_q;
    logic              ack_s1_q, ack_s_q;
    logic [15:0]       cnt_q;
    logic              load_q, tick_q;
    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic [AW:0]       wr_ptr_q, rd_ptr_q;
    logic              overrun_q, timeout_q;
    logic [15:0]       missed_q;
    logic [31:0]       count_q;

    logic [15:0] reload_d, cnt_cur_d;
    logic        empty_d, full_d, pop_d, push_req_d, push_d, drop_d, expire_d, missed_ev_d;

    // load_q stands in for "counter sits at the reload value", so reset needs no period input
    always_comb begin
        reload_d    = (period_i < 16'd4) ? 16'd3 : period_i - 16'd1;
        cnt_cur_d   = load_q ? reload_d : cnt_q;
        empty_d     = (wr_ptr_q == rd_ptr_q);
        full_d      = ((wr_ptr_q - rd_ptr_q) == DEPTH_L);
        pop_d       = !empty_d && bus.out_ready;
        push_req_d  = (state_q == REQ) && ack_s_q;
        push_d      = push_req_d && (!full_d || pop_d);
        drop_d      = push_req_d && full_d && !pop_d;
        expire_d    = (state_q == REQ) && !ack_s_q && (to_cnt_q == TO_LAST);
        missed_ev_d = tick_q && (state_q != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack_s1_q <= 1'b0;
            ack_s_q  <= 1'b0;
            cnt_q    <= '0;
            load_q   <= 1'b1;
            tick_q   <= 1'b0;
        end else begin
            ack_s1_q <= bus.ack;
            ack_s_q  <= ack_s1_q;
            if (!enable_i) begin
                load_q <= 1'b1;
                tick_q <= 1'b0;
            end else if (cnt_cur_d == 16'd0) begin
                load_q <= 1'b1;
                tick_q <= 1'b1;
            end else begin
                cnt_q  <= cnt_cur_d - 16'd1;
                load_q <= 1'b0;
                tick_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            req_q    <= 1'b0;
            to_cnt_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (tick_q) begin
                        state_q  <= REQ;
                        req_q    <= 1'b1;
                        to_cnt_q <= '0;
                    end
                end
                REQ: begin
                    if (ack_s_q || expire_d) begin
                        state_q <= WAIT_LOW;
                        req_q   <= 1'b0;
                    end else begin
                        to_cnt_q <= to_cnt_q + TW'(1);
                    end
                end
                WAIT_LOW: begin
                    if (!ack_s_q) state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    req_q   <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push_d) begin
                mem_q[wr_ptr_q[AW-1:0]] <= bus.sample;
                wr_ptr_q                <= wr_ptr_q + 1'b1;
            end
            if (pop_d) rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    // clear has priority over any flag or counter event in the same cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overrun_q <= 1'b0;
            timeout_q <= 1'b0;
            missed_q  <= '0;
            count_q   <= '0;
        end else if (clear_i) begin
            overrun_q <= 1'b0;
            timeout_q <= 1'b0;
            missed_q  <= '0;
            count_q   <= '0;
        end else begin
            if (drop_d)   overrun_q <= 1'b1;
            if (expire_d) timeout_q <= 1'b1;
            if (missed_ev_d && (missed_q != 16'hFFFF)) missed_q <= missed_q + 16'd1;
            if (push_d)   count_q <= count_q + 32'd1;
        end
    end

    assign bus.req        = req_q;
    assign bus.out_valid  = !empty_d;
    assign bus.out_data   = mem_q[rd_ptr_q[AW-1:0]];
    assign overrun_o      = overrun_q;
    assign timeout_o      = timeout_q;
    assign missed_o       = missed_q;
    assign sample_count_o = count_q;
endmodule

// File: tb/tb_gpio_sample_requester.sv
// Bench for gpio_sample_requester: directed vector table, timeout / overrun /
// reset sequences and randomized traffic against a timeline reference model.
module tb_gpio_sample_requester;
    localparam int DATA_W  = 16;
    localparam int DEPTH   = 8;
    localparam int TIMEOUT = 1024;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic        clear = 1'b0;
    logic [15:0] period = 16'd10;
    logic        overrun, timeout;
    logic [15:0] missed;
    logic [31:0] sample_count;

    always #5 clk = ~clk;

    gpio_sample_requester_if #(.DATA_W(DATA_W)) bus ();

    gpio_sample_requester #(.DATA_W(DATA_W), .FIFO_DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus),
        .enable_i(enable), .period_i(period), .clear_i(clear),
        .overrun_o(overrun), .timeout_o(timeout),
        .missed_o(missed), .sample_count_o(sample_count)
    );

    int n_checks = 0;
    int n_pass = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // core model: raises ack core_delay cycles into a request with a fresh word, drops it when req falls
    logic        core_en = 1'b1;
    int          core_delay = 3;
    int          hcnt = 0;
    logic [15:0] core_sample = '0;
    logic [15:0] sent_q [$];

    always @(negedge clk) begin
        if (!rst_n) begin
            bus.ack = 1'b0;
            hcnt    = 0;
        end else if (bus.req && core_en) begin
            hcnt++;
            if (hcnt >= core_delay && !bus.ack) begin
                core_sample = 16'($urandom);
                bus.sample  = core_sample;
                bus.ack     = 1'b1;
                sent_q.push_back(core_sample);
            end
        end else begin
            bus.ack = 1'b0;
            hcnt    = 0;
        end
    end

    typedef struct {
        int period; int delay; int cycles;
        int exp_first; int exp_gap; int exp_count; int exp_missed;
    } vec_t;
    vec_t vecs [6];

    task automatic apply_reset();
        rst_n = 1'b0; enable = 1'b0; clear = 1'b0; bus.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_ack(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk); #1;
            if (bus.ack) begin ok = 1'b1; break; end
        end
    endtask

    task automatic run_vector(input int idx, input vec_t v);
        int first_rise, second_rise;
        logic prev;
        apply_reset();
        period = 16'(v.period); core_delay = v.delay; core_en = 1'b1; bus.out_ready = 1'b1;
        @(posedge clk); #1; enable = 1'b1;
        first_rise = -1; second_rise = -1; prev = 1'b0;
        for (int n = 1; n <= v.cycles; n++) begin
            @(posedge clk); #1;
            if (bus.req && !prev) begin
                if (first_rise < 0) first_rise = n;
                else if (second_rise < 0) second_rise = n;
            end
            prev = bus.req;
        end
        check($sformatf("vec%0d_first_req", idx), first_rise, v.exp_first);
        check($sformatf("vec%0d_req_gap", idx), second_rise - first_rise, v.exp_gap);
        check($sformatf("vec%0d_count", idx), sample_count, v.exp_count);
        check($sformatf("vec%0d_missed", idx), missed, v.exp_missed);
        check($sformatf("vec%0d_drained", idx), bus.out_valid, 0);
        clear = 1'b1; @(posedge clk); #1; clear = 1'b0;
        check($sformatf("vec%0d_clr_missed", idx), missed, 0);
        check($sformatf("vec%0d_clr_count", idx), sample_count, 0);
    endtask

    // reference: ticks every pe cycles; a tick at t is taken iff the previous
    // handshake has returned to idle (t >= R+D+5); req is high over [R, R+D+2)
    task automatic run_random(input int cycles);
        int p_in, pe, d, rdy_pct, next_free, r, cap, missed_m, count_m, t;
        bit ovr_m, rdy, clr, req_exp;
        logic [15:0] q [$];
        p_in = $urandom_range(0, 12);
        pe = (p_in < 4) ? 4 : p_in;
        d = $urandom_range(1, 8);
        rdy_pct = $urandom_range(2, 40);
        apply_reset();
        period = 16'(p_in); core_delay = d; core_en = 1'b1;
        next_free = 0; r = -100; cap = -100; missed_m = 0; count_m = 0; ovr_m = 1'b0;
        @(posedge clk); #1; enable = 1'b1;
        for (int n = 1; n <= cycles; n++) begin
            rdy = bus.out_ready; clr = clear;
            @(posedge clk); #1;
            if (rdy && q.size() > 0) void'(q.pop_front());
            if (n == cap) begin
                if (q.size() < DEPTH) begin q.push_back(core_sample); count_m++; end
                else ovr_m = 1'b1;
            end
            t = n - 1;
            if (t > 0 && (t % pe) == 0) begin
                if (t >= next_free) begin r = n; cap = r + d + 2; next_free = r + d + 5; end
                else missed_m++;
            end
            if (clr) begin missed_m = 0; count_m = 0; ovr_m = 1'b0; end
            req_exp = (n >= r) && (n < cap);
            check("rnd_req", bus.req, req_exp);
            check("rnd_valid", bus.out_valid, q.size() > 0);
            if (q.size() > 0) check("rnd_data", bus.out_data, q[0]);
            check("rnd_missed", missed, missed_m);
            check("rnd_count", sample_count, count_m);
            check("rnd_overrun", overrun, ovr_m);
            check("rnd_timeout", timeout, 0);
            bus.out_ready = ($urandom_range(0, 99) < rdy_pct);
            clear = ($urandom_range(0, 79) == 0);
        end
        clear = 1'b0;
    endtask

    initial begin
        int hi, second, base;
        logic prev;
        bit ok;
        logic [15:0] exp_w;

        vecs[0] = '{10, 3, 100, 11, 10, 9, 0};
        vecs[1] = '{4, 10, 100, 5, 16, 6, 18};
        vecs[2] = '{2, 1, 100, 5, 8, 12, 12};
        vecs[3] = '{6, 1, 60, 7, 12, 5, 4};
        vecs[4] = '{7, 1, 70, 8, 7, 9, 0};
        vecs[5] = '{0, 2, 40, 5, 8, 4, 4};

        apply_reset();
        #1;
        check("rst_req", bus.req, 0);
        check("rst_valid", bus.out_valid, 0);
        check("rst_data", bus.out_data, 0);
        check("rst_overrun", overrun, 0);
        check("rst_timeout", timeout, 0);
        check("rst_missed", missed, 0);
        check("rst_count", sample_count, 0);

        for (int i = 0; i < 6; i++) run_vector(i, vecs[i]);

        // core never answers: request abandoned after TIMEOUT cycles
        apply_reset();
        period = 16'd10; core_en = 1'b0; bus.out_ready = 1'b1;
        @(posedge clk); #1; enable = 1'b1;
        hi = 0; second = -1; prev = 1'b0;
        for (int n = 1; n <= 1045; n++) begin
            @(posedge clk); #1;
            if (bus.req && n < 1036) hi++;
            if (n == 1034) begin check("to_req_last", bus.req, 1); check("to_flag_early", timeout, 0); end
            if (n == 1035) begin check("to_req_drop", bus.req, 0); check("to_flag", timeout, 1); end
            if (n == 1040) check("to_missed", missed, 102);
            if (bus.req && !prev && n > 11 && second < 0) second = n;
            prev = bus.req;
        end
        check("to_req_cycles", hi, TIMEOUT);
        check("to_next_req", second, 1041);
        check("to_no_push", sample_count, 0);
        check("to_empty", bus.out_valid, 0);
        core_en = 1'b1;

        // fill, overrun, clear, push+pop while full, drain in order
        apply_reset();
        period = 16'd10; core_delay = 3; base = sent_q.size();
        @(posedge clk); #1; enable = 1'b1;
        repeat (100) @(posedge clk); #1;
        check("ovf_sent", sent_q.size() - base, 9);
        check("ovf_count", sample_count, 8);
        check("ovf_flag", overrun, 1);
        check("ovf_valid", bus.out_valid, 1);
        check("ovf_head", bus.out_data, sent_q[base]);
        clear = 1'b1; @(posedge clk); #1; clear = 1'b0;
        check("clr_overrun", overrun, 0);
        check("clr_count", sample_count, 0);
        wait_ack(ok);
        check("fp_ack_seen", ok, 1);
        @(posedge clk); @(posedge clk); #1; bus.out_ready = 1'b1;
        @(posedge clk); #1;
        check("fp_overrun", overrun, 0);
        check("fp_count", sample_count, 1);
        check("fp_head", bus.out_data, sent_q[base + 1]);
        enable = 1'b0;
        for (int i = 0; i < 8; i++) begin
            exp_w = (i < 7) ? sent_q[base + 1 + i] : sent_q[base + 9];
            check("drain_valid", bus.out_valid, 1);
            check("drain_data", bus.out_data, exp_w);
            @(posedge clk); #1;
        end
        check("drain_empty", bus.out_valid, 0);
        bus.out_ready = 1'b0;

        // asynchronous reset in the middle of a handshake
        apply_reset();
        period = 16'd10; core_delay = 3;
        @(posedge clk); #1; enable = 1'b1;
        repeat (20) @(posedge clk); #1;
        check("ar_pre_valid", bus.out_valid, 1);
        wait_ack(ok);
        check("ar_ack_seen", ok, 1);
        #1;
        check("ar_pre_req", bus.req, 1);
        rst_n = 1'b0; #1;
        check("ar_req", bus.req, 0);
        check("ar_valid", bus.out_valid, 0);
        check("ar_data", bus.out_data, 0);
        check("ar_count", sample_count, 0);
        @(negedge clk); #2; rst_n = 1'b1;
        repeat (5) @(posedge clk); #1;
        check("ar_no_capture", sample_count, 0);
        check("ar_no_req", bus.req, 0);
        repeat (25) @(posedge clk); #1;
        check("ar_fresh_count", sample_count, 2);

        for (int s = 0; s < 4; s++) run_random(300);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no completion, expected finish before time limit");
        $fatal(1);
    end
endmodule
